// File: rtl/inflate_bit_unpacker.sv
// Inflate bit unpacker: packs LSB-first words into a shift buffer for the decoder.
// Define INFLATE_BIT_UNPACKER_STAT_EN to add the stat_bits consumed-bit counter.
module inflate_bit_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_WIDTH  = 64,
  parameter int PEEK_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(BUF_WIDTH + 1),
  parameter int LEN_WIDTH  = $clog2(PEEK_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  src_vld,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_rdy,
  input  logic                  cns_vld,
  input  logic [LEN_WIDTH-1:0]  cns_len,
  output logic                  cns_rdy,
  input  logic                  align_req,
  output logic [PEEK_WIDTH-1:0] peek_data,
  output logic [CNT_WIDTH-1:0]  bit_cnt,
  output logic                  cns_err
`ifdef INFLATE_BIT_UNPACKER_STAT_EN
  ,
  output logic [31:0]           stat_bits
`endif
);

  localparam logic [CNT_WIDTH-1:0] FILL_MAX =
    CNT_WIDTH'(BUF_WIDTH - DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] DW_C = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] PW_C = LEN_WIDTH'(PEEK_WIDTH);

  logic [BUF_WIDTH-1:0] buf_q, buf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rdy_q, rdy_d;
  logic                 err_q, err_d;

  logic [CNT_WIDTH-1:0] len_c;
  logic [CNT_WIDTH-1:0] d;
  logic [CNT_WIDTH-1:0] base;
  logic [BUF_WIDTH-1:0] sh;
  logic [BUF_WIDTH-1:0] ins;
  logic                 len_ok;
  logic                 cns_acc;
  logic                 src_acc;

  assign len_c   = CNT_WIDTH'(cns_len);
  assign len_ok  = (cns_len <= PW_C);
  assign cns_rdy = (len_c <= cnt_q) & ~align_req & len_ok;
  assign cns_acc = cns_vld & cns_rdy;
  assign src_acc = src_vld & rdy_q;

  always_comb begin
    d = '0;
    unique case (1'b1)
      align_req: d = CNT_WIDTH'(cnt_q[2:0]);
      cns_acc:   d = len_c;
      default:   d = '0;
    endcase
  end

  // Shift out consumed bits first, then drop the new word right above the rest.
  always_comb begin
    base  = cnt_q - d;
    sh    = buf_q >> d;
    ins   = BUF_WIDTH'(src_data) << base;
    buf_d = src_acc ? (sh | ins) : sh;
    cnt_d = base + (src_acc ? DW_C : '0);
    rdy_d = (cnt_d <= FILL_MAX);
    err_d = err_q | (cns_vld & ~len_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b1;
      err_q <= 1'b0;
    end else if (flush) begin
      buf_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
    end
  end

  assign peek_data = buf_q[PEEK_WIDTH-1:0];
  assign bit_cnt   = cnt_q;
  assign src_rdy   = rdy_q;
  assign cns_err   = err_q;

`ifdef INFLATE_BIT_UNPACKER_STAT_EN
  logic [31:0] stat_q, stat_d;
  logic [32:0] stat_sum;

  assign stat_sum = {1'b0, stat_q} + 33'(d);
  assign stat_d   = stat_sum[32] ? 32'hFFFF_FFFF : stat_sum[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (flush) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_bits = stat_q;
`endif

endmodule

// File: tb/tb_inflate_bit_unpacker.sv
// Bench for inflate_bit_unpacker: directed scenarios plus random traffic
// checked against a bit-queue model of the stream.
module tb_inflate_bit_unpacker;
  localparam int DW = 32;
  localparam int BW = 64;
  localparam int PW = 32;
  localparam int CW = $clog2(BW + 1);
  localparam int LW = $clog2(PW + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          src_vld = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_rdy;
  logic          cns_vld = 1'b0;
  logic [LW-1:0] cns_len = '0;
  logic          cns_rdy;
  logic          align_req = 1'b0;
  logic [PW-1:0] peek_data;
  logic [CW-1:0] bit_cnt;
  logic          cns_err;
`ifdef INFLATE_BIT_UNPACKER_STAT_EN
  logic [31:0]   stat_bits;
`endif

  inflate_bit_unpacker #(
    .DATA_WIDTH(DW),
    .BUF_WIDTH(BW),
    .PEEK_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .src_vld(src_vld),
    .src_data(src_data),
    .src_rdy(src_rdy),
    .cns_vld(cns_vld),
    .cns_len(cns_len),
    .cns_rdy(cns_rdy),
    .align_req(align_req),
    .peek_data(peek_data),
    .bit_cnt(bit_cnt),
    .cns_err(cns_err)
`ifdef INFLATE_BIT_UNPACKER_STAT_EN
    ,
    .stat_bits(stat_bits)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the buffered stream as a queue of bits, oldest first.
  bit     mq[$];
  bit     m_rdy = 1'b1;
  bit     m_err = 1'b0;
  longint m_stat = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] m_peek();
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < PW; i++)
      if (i < mq.size()) p[i] = mq[i];
    return p;
  endfunction

  task automatic m_clear();
    mq.delete();
    m_rdy = 1'b1;
    m_err = 1'b0;
    m_stat = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cnt"}, 64'(bit_cnt), 64'(mq.size()));
    chk({tag, "_peek"}, 64'(peek_data), 64'(m_peek()));
    chk({tag, "_srdy"}, 64'(src_rdy), 64'(m_rdy));
    chk({tag, "_err"}, 64'(cns_err), 64'(m_err));
`ifdef INFLATE_BIT_UNPACKER_STAT_EN
    chk({tag, "_stat"}, 64'(stat_bits), 64'(m_stat));
`endif
  endtask

  // One clock: drive inputs, check cns_rdy mid-cycle, advance model, check.
  task automatic cyc(input string tag, input bit sv, input logic [DW-1:0] sd,
                     input bit cv, input int cl, input bit al, input bit fl);
    int d;
    bit crdy;
    bit acc_w;
    src_vld = sv;
    src_data = sd;
    cns_vld = cv;
    cns_len = LW'(cl);
    align_req = al;
    flush = fl;
    @(negedge clk);
    crdy = (cl <= mq.size()) && !al && (cl <= PW);
    chk({tag, "_crdy"}, 64'(cns_rdy), 64'(crdy));
    acc_w = sv && m_rdy;
    if (fl) begin
      m_clear();
    end else begin
      if (cv && cl > PW) m_err = 1'b1;
      if (al) d = mq.size() % 8;
      else if (cv && crdy) d = cl;
      else d = 0;
      repeat (d) void'(mq.pop_front());
      if (acc_w)
        for (int i = 0; i < DW; i++) mq.push_back(sd[i]);
      m_stat = m_stat + d;
      if (m_stat > 64'hFFFF_FFFF) m_stat = 64'hFFFF_FFFF;
      m_rdy = (mq.size() <= BW - DW);
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle_in();
    src_vld = 1'b0;
    cns_vld = 1'b0;
    cns_len = '0;
    align_req = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_cnt", 64'(bit_cnt), 64'd0);
    chk("rst_peek", 64'(peek_data), 64'd0);
    chk("rst_srdy", 64'(src_rdy), 64'd1);
    chk("rst_err", 64'(cns_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cyc("push1", 1, 32'h04030201, 0, 0, 0, 0);
    chk("tp_push_cnt", 64'(bit_cnt), 64'd32);
    chk("tp_push_peek", 64'(peek_data), 64'h04030201);
    chk("tp_push_srdy", 64'(src_rdy), 64'd1);
    cyc("cns3", 0, '0, 1, 3, 0, 0);
    chk("tp_cns3_cnt", 64'(bit_cnt), 64'd29);
    chk("tp_cns3_peek", 64'(peek_data[15:0]), 64'h6040);
    cyc("align", 0, '0, 0, 0, 1, 0);
    chk("tp_align_cnt", 64'(bit_cnt), 64'd24);
    chk("tp_align_peek", 64'(peek_data[15:0]), 64'h0302);
    cyc("align0", 0, '0, 1, 4, 1, 0);
    chk("tp_align0_cnt", 64'(bit_cnt), 64'd24);

    cyc("fl1", 0, '0, 0, 0, 0, 1);
    cyc("pa", 1, 32'h04030201, 0, 0, 0, 0);
    cyc("pb", 1, 32'h08070605, 0, 0, 0, 0);
    chk("tp_full_cnt", 64'(bit_cnt), 64'd64);
    chk("tp_full_srdy", 64'(src_rdy), 64'd0);
    cyc("pblk", 1, 32'hDEADBEEF, 1, 31, 0, 0);
    chk("tp_c31_cnt", 64'(bit_cnt), 64'd33);
    chk("tp_c31_srdy", 64'(src_rdy), 64'd0);
    cyc("c1", 0, '0, 1, 1, 0, 0);
    chk("tp_c1_cnt", 64'(bit_cnt), 64'd32);
    chk("tp_c1_srdy", 64'(src_rdy), 64'd1);

    cyc("fl2", 0, '0, 0, 0, 0, 1);
    cyc("pc", 1, 32'h04030201, 0, 0, 0, 0);
    cyc("both", 1, 32'hAABBCCDD, 1, 16, 0, 0);
    chk("tp_both_cnt", 64'(bit_cnt), 64'd48);
    chk("tp_both_peek", 64'(peek_data), 64'hCCDD0403);

    cyc("fl3", 0, '0, 0, 0, 0, 1);
    cyc("pd", 1, 32'h5A5A5A5A, 0, 0, 0, 0);
    cyc("c27", 0, '0, 1, 27, 0, 0);
    cyc("stall", 0, '0, 1, 9, 0, 0);
    chk("tp_stall_cnt", 64'(bit_cnt), 64'd5);
    cyc("z0", 0, '0, 1, 0, 0, 0);
    cyc("pe", 1, 32'h13579BDF, 1, 2, 0, 0);
    cyc("fl4", 1, 32'hFFFFFFFF, 1, 33, 1, 1);
    chk("tp_flush_cnt", 64'(bit_cnt), 64'd0);
    chk("tp_flush_srdy", 64'(src_rdy), 64'd1);

    cyc("pf", 1, 32'h0BADF00D, 0, 0, 0, 0);
    cyc("bad", 0, '0, 1, PW + 1, 0, 0);
    chk("tp_err_set", 64'(cns_err), 64'd1);
    cyc("hold", 0, '0, 1, 4, 0, 0);
    chk("tp_err_hold", 64'(cns_err), 64'd1);
    cyc("fl5", 0, '0, 0, 0, 0, 1);
    chk("tp_err_clr", 64'(cns_err), 64'd0);

    cyc("pg", 1, 32'hCAFEBABE, 0, 0, 0, 0);
    cyc("ph", 1, 32'h12345678, 1, 7, 0, 0);
    cyc("pi", 0, '0, 1, PW + 2, 0, 0);
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 64'(bit_cnt), 64'd0);
    chk("arst_peek", 64'(peek_data), 64'd0);
    chk("arst_srdy", 64'(src_rdy), 64'd1);
    chk("arst_err", 64'(cns_err), 64'd0);
`ifdef INFLATE_BIT_UNPACKER_STAT_EN
    chk("arst_stat", 64'(stat_bits), 64'd0);
`endif
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 2000; n++) begin
      bit sv, cv, al, fl;
      int cl;
      sv = ($urandom_range(0, 3) != 0);
      cv = ($urandom_range(0, 2) != 0);
      cl = ($urandom_range(0, 19) == 0) ? $urandom_range(PW + 1, PW + 3)
                                         : $urandom_range(0, PW);
      al = ($urandom_range(0, 11) == 0);
      fl = ($urandom_range(0, 79) == 0);
      cyc("rnd", sv, DW'($urandom), cv, cl, al, fl);
    end

    idle_in();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
